// File: rtl/multi_stage_lock_pkg.sv
// Shared state encoding and 7-segment patterns for the multi-stage password lock.
package multi_stage_lock_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } lock_state_t;

  localparam logic [8:0] SEG_LOCKED  = 9'h039;
  localparam logic [8:0] SEG_OPEN    = 9'h03f;
  localparam logic [8:0] SEG_LOCKOUT = 9'h038;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_stage_lock_button_debounce.sv
// Active-low button conditioner: 2-flop synchroniser, stable-level filter and
// a one-cycle pulse on each accepted press (debounced 1->0).
module button_debounce #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic Btn_Raw,
  output logic Btn_Level,
  output logic Press_Pulse
);

  logic        sync1;
  logic        sync2;
  logic [19:0] cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      Btn_Level   <= 1'b1;
      cnt         <= '0;
      Press_Pulse <= 1'b0;
    end else begin
      sync1       <= Btn_Raw;
      sync2       <= sync1;
      Press_Pulse <= 1'b0;
      // Level flips on the DEB_CYCLES-th consecutive differing sample.
      if (sync2 == Btn_Level) begin
        cnt <= '0;
      end else if (cnt == DEB_CYCLES - 20'd1) begin
        Btn_Level   <= sync2;
        cnt         <= '0;
        Press_Pulse <= ~sync2;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/multi_stage_lock.sv
// N-stage password lock with debounced confirm/relock buttons, wrong-attempt
// lockout and optional auto-relock, driving progress LEDs and one 7-seg digit.
module multi_stage_lock
  import multi_stage_lock_pkg::*;
#(
  parameter int unsigned                N_STAGES    = 2,
  parameter int unsigned                KEY_W       = 4,
  parameter logic [N_STAGES*KEY_W-1:0]  PASSWORDS   = 8'h5A,
  parameter logic [19:0]                DEB_CYCLES  = 20'd500000,
  parameter int unsigned                MAX_FAIL    = 3,
  parameter logic [31:0]                LOCKOUT_CYC = 32'd50000000,
  parameter logic [31:0]                OPEN_CYC    = 32'd0
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [KEY_W-1:0]    Key,
  input  logic                Button,
  input  logic                Button_Rl,
  output logic [N_STAGES-1:0] LED,
  output logic [8:0]          Seg_Led,
  output logic                Opened
);

  localparam int unsigned    IW        = idx_width(N_STAGES);
  localparam int unsigned    FW        = $clog2(MAX_FAIL + 1);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(N_STAGES - 1);
  localparam logic [FW-1:0]  FAIL_MAX  = FW'(MAX_FAIL);
  localparam logic [FW-1:0]  FAIL_LAST = FW'(MAX_FAIL - 1);

  logic [1:0]       rst_pipe;
  logic             rst_n_int;
  logic             conf_level, conf_pulse, rl_level, rl_pulse;
  logic             confirm, relock;
  logic [KEY_W-1:0] code_sel;
  lock_state_t      state;
  logic [IW-1:0]    idx;
  logic [FW-1:0]    fail_cnt;
  logic [31:0]      timer;

  // Asynchronous assert, synchronous release for everything downstream.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rst_pipe <= '0;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n_int = rst_pipe[1];

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_conf_deb (
    .Clk(Clk), .Rst_n(rst_n_int), .Btn_Raw(Button),
    .Btn_Level(conf_level), .Press_Pulse(conf_pulse)
  );

  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rl_deb (
    .Clk(Clk), .Rst_n(rst_n_int), .Btn_Raw(Button_Rl),
    .Btn_Level(rl_level), .Press_Pulse(rl_pulse)
  );

  assign confirm = conf_pulse & ~conf_level;
  assign relock  = rl_pulse & ~rl_level;

  always_comb begin
    code_sel = '0;
    for (int unsigned i = 0; i < N_STAGES; i++) begin
      if (idx == IW'(i)) code_sel = PASSWORDS[i*KEY_W +: KEY_W];
    end
  end

  always_ff @(posedge Clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state    <= LOCKED;
      idx      <= '0;
      fail_cnt <= '0;
      timer    <= '0;
      LED      <= '1;
      Seg_Led  <= SEG_LOCKED;
      Opened   <= 1'b0;
    end else begin
      case (state)
        LOCKED: begin
          if (relock) begin
            idx <= '0;
            LED <= '1;
          end else if (confirm) begin
            if (Key == code_sel) begin
              if (idx == LAST_IDX) begin
                state    <= OPEN;
                LED      <= '0;
                fail_cnt <= '0;
                timer    <= OPEN_CYC;
                Seg_Led  <= SEG_OPEN;
                Opened   <= 1'b1;
              end else begin
                idx      <= idx + 1'b1;
                LED[idx] <= 1'b0;
              end
            end else begin
              idx <= '0;
              LED <= '1;
              if (fail_cnt != FAIL_MAX) fail_cnt <= fail_cnt + 1'b1;
              if (fail_cnt == FAIL_LAST) begin
                state   <= LOCKOUT;
                timer   <= LOCKOUT_CYC;
                Seg_Led <= SEG_LOCKOUT;
              end
            end
          end
        end
        OPEN: begin
          if (relock || (OPEN_CYC != 32'd0 && timer == 32'd1)) begin
            state   <= LOCKED;
            idx     <= '0;
            LED     <= '1;
            timer   <= '0;
            Seg_Led <= SEG_LOCKED;
            Opened  <= 1'b0;
          end else if (timer != 32'd0) begin
            timer <= timer - 32'd1;
          end
        end
        LOCKOUT: begin
          if (timer <= 32'd1) begin
            state    <= LOCKED;
            idx      <= '0;
            fail_cnt <= '0;
            timer    <= '0;
            LED      <= '1;
            Seg_Led  <= SEG_LOCKED;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        default: state <= LOCKED;
      endcase
    end
  end

endmodule
